// File: rtl/loop_mux.sv
// loop_mux: loop-descriptor decoder.
// Holds the program's loop read-only table: one entry per loop name, made of
// an iteration count and a backward jump amount. A decode request returns the
// registered fields of the entry selected by addr, together with the
// instruction flag bits.
// Optional feature: define LOOP_MUX_ZERO_CHECK_EN to build the err output.
// It flags a start-loop decode whose entry has a zero iteration count or a
// zero jump amount. Without the macro, err is tied low.
module loop_mux #(
  parameter  int LOG_LOOP_CNT = 3,
  parameter  int ITER_W       = 18,
  parameter  int JUMP_W       = 6,
  localparam int LOOP_CNT     = 1 << LOG_LOOP_CNT,
  localparam int ENTRY_W      = ITER_W + JUMP_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        load,
  input  logic [ENTRY_W*LOOP_CNT-1:0] in,
  input  logic                        decode,
  input  logic [LOG_LOOP_CNT-1:0]     addr,
  input  logic                        independent,
  input  logic                        new_loop,
  output logic                        out_valid,
  output logic                        is_new_loop,
  output logic                        is_independent,
  output logic [ITER_W-1:0]           iteration_count,
  output logic [JUMP_W-1:0]           jump_amount,
  output logic [LOG_LOOP_CNT-1:0]     name,
  output logic                        err
);

  logic [ENTRY_W-1:0] loop_table [LOOP_CNT];
  logic [ENTRY_W-1:0] sel_entry;
  logic [ITER_W-1:0]  sel_iter;
  logic [JUMP_W-1:0]  sel_jump;

  // The decode path reads the table as it stood before this edge. A load in
  // the same cycle therefore becomes visible only to the next decode.
  assign sel_entry = loop_table[addr];
  assign sel_iter  = sel_entry[ENTRY_W-1:JUMP_W];
  assign sel_jump  = sel_entry[JUMP_W-1:0];

  // Table storage: the whole table is captured from `in` on a load.
  // NOTE: this array is reset explicitly because decodes after reset must
  // return zero fields. Do not drop the reset to save flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LOOP_CNT; i++) loop_table[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < LOOP_CNT; i++)
        loop_table[i] <= in[i*ENTRY_W +: ENTRY_W];
    end
  end

  // Output registers: valid pulses with each decode, and data holds otherwise.
  // NOTE: non-blocking assignments make every register in this block sample
  // pre-edge values. That is what lets the decode read the pre-load table.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid       <= 1'b0;
      is_new_loop     <= 1'b0;
      is_independent  <= 1'b0;
      iteration_count <= '0;
      jump_amount     <= '0;
      name            <= '0;
    end else begin
      out_valid <= decode;
      if (decode) begin
        is_new_loop     <= new_loop;
        is_independent  <= independent & new_loop;
        iteration_count <= sel_iter;
        jump_amount     <= sel_jump;
        name            <= addr;
      end
    end
  end

`ifdef LOOP_MUX_ZERO_CHECK_EN
  // Descriptor check: a start-loop must not use a zero count or a zero jump.
  // The flag is registered so that it lines up with the decoded fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else begin
      err <= decode & new_loop & ((sel_iter == '0) | (sel_jump == '0));
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_loop_mux.sv
// tb_loop_mux: directed self-checking bench for loop_mux.
// Inputs change 1 time unit after a rising edge. Outputs are checked 1 time
// unit after the edge that registers them.
module tb_loop_mux;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         load;
  logic [191:0] in_bus;
  logic         decode;
  logic [2:0]   addr;
  logic         independent;
  logic         new_loop;
  logic         out_valid;
  logic         is_new_loop;
  logic         is_independent;
  logic [17:0]  iteration_count;
  logic [5:0]   jump_amount;
  logic [2:0]   name;
  logic         err;

  int passed = 0;
  int total  = 0;
  logic exp_err_on;

  loop_mux dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .load            (load),
    .in              (in_bus),
    .decode          (decode),
    .addr            (addr),
    .independent     (independent),
    .new_loop        (new_loop),
    .out_valid       (out_valid),
    .is_new_loop     (is_new_loop),
    .is_independent  (is_independent),
    .iteration_count (iteration_count),
    .jump_amount     (jump_amount),
    .name            (name),
    .err             (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle before checking or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef LOOP_MUX_ZERO_CHECK_EN
    exp_err_on = 1'b1;
`else
    exp_err_on = 1'b0;
`endif
    reset_n = 1'b0; load = 1'b0; in_bus = '0; decode = 1'b0;
    addr = '0; independent = 1'b0; new_loop = 1'b0;
    step(); step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_iter",  32'(iteration_count), 32'd0);
    check("rst_name",  32'(name), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    reset_n = 1'b1;
    step();

    // Decode from the reset-cleared table.
    decode = 1'b1; addr = 3'd5;
    step();
    check("r_valid", 32'(out_valid), 32'd1);
    check("r_iter",  32'(iteration_count), 32'd0);
    check("r_jump",  32'(jump_amount), 32'd0);
    check("r_name",  32'(name), 32'd5);
    decode = 1'b0; addr = 3'd1;
    step();
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_hold_name", 32'(name), 32'd5);

    // Load entry3 = {100, 4}, then decode a start-loop.
    in_bus = '0; in_bus[3*24 +: 24] = {18'd100, 6'd4}; load = 1'b1;
    step();
    load = 1'b0; decode = 1'b1; addr = 3'd3; new_loop = 1'b1; independent = 1'b1;
    step();
    check("ld_iter", 32'(iteration_count), 32'd100);
    check("ld_jump", 32'(jump_amount), 32'd4);
    check("ld_new",  32'(is_new_loop), 32'd1);
    check("ld_ind",  32'(is_independent), 32'd1);
    check("ld_name", 32'(name), 32'd3);

    // End-loop gates off the independent flag.
    new_loop = 1'b0; independent = 1'b1;
    step();
    check("end_new",  32'(is_new_loop), 32'd0);
    check("end_ind",  32'(is_independent), 32'd0);
    check("end_iter", 32'(iteration_count), 32'd100);
    check("end_err",  32'(err), 32'd0);

    // Load/decode collision: the decode must see the old entry0.
    decode = 1'b0; independent = 1'b0;
    in_bus = '0; in_bus[0 +: 24] = {18'd7, 6'd2}; load = 1'b1;
    step();
    in_bus[0 +: 24] = {18'd9, 6'd1}; decode = 1'b1; addr = 3'd0;
    step();
    check("col_old_iter", 32'(iteration_count), 32'd7);
    check("col_old_jump", 32'(jump_amount), 32'd2);
    load = 1'b0;
    step();
    check("col_new_iter", 32'(iteration_count), 32'd9);
    check("col_new_jump", 32'(jump_amount), 32'd1);

    // All eight entries, decoded back to back.
    decode = 1'b0;
    for (int i = 0; i < 8; i++) in_bus[i*24 +: 24] = {18'(i + 1), 6'(i + 1)};
    load = 1'b1;
    step();
    load = 1'b0; decode = 1'b1; new_loop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr = 3'(i);
      step();
      check($sformatf("all_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("all_iter%0d", i),  32'(iteration_count), 32'(i + 1));
      check($sformatf("all_jump%0d", i),  32'(jump_amount), 32'(i + 1));
      check($sformatf("all_name%0d", i),  32'(name), 32'(i));
    end

    // Zero iteration count in entry2.
    decode = 1'b0;
    in_bus[2*24 +: 24] = {18'd0, 6'd3}; load = 1'b1;
    step();
    load = 1'b0; decode = 1'b1; addr = 3'd2; new_loop = 1'b1;
    step();
    check("zc_err_start", 32'(err), 32'(exp_err_on));
    check("zc_iter", 32'(iteration_count), 32'd0);
    check("zc_jump", 32'(jump_amount), 32'd3);
    new_loop = 1'b0;
    step();
    check("zc_err_end", 32'(err), 32'd0);
    decode = 1'b0;
    step();
    check("zc_err_idle", 32'(err), 32'd0);

    // A mid-operation reset clears the table and drops the in-flight decode.
    decode = 1'b1; addr = 3'd7; new_loop = 1'b1;
    step();
    check("pre_rst_iter", 32'(iteration_count), 32'd8);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_iter",  32'(iteration_count), 32'd0);
    check("mid_rst_new",   32'(is_new_loop), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_iter", 32'(iteration_count), 32'd0);
    check("post_rst_jump", 32'(jump_amount), 32'd0);
    check("post_rst_valid", 32'(out_valid), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/loop_mux.md
# loop_mux

Loop-descriptor decoder for the control unit's loop instructions. It holds the program's loop read-only table, which has one entry per loop name: an iteration count and a backward jump amount. On each decode request it returns a registered, decoded loop instruction built from the table entry selected by the instruction's 3-bit loop address plus the instruction's flag bits. It sits between the program-header ro_data port and the control unit's DECODE / START_NEW_LOOP / INCREMENT_LOOP path.

## Interface
- LOG_LOOP_CNT, 3, log2 of table entries (LOOP_CNT = 8).
- ITER_W, 18, iteration-count field width.
- JUMP_W, 6, jump-amount field width; entry width ENTRY_W = ITER_W + JUMP_W (24).

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load  in  1  capture the whole table from `in` this cycle.
- in  in  ENTRY_W*LOOP_CNT (192)  packed loop ro_data; entry i = in[i*24 +: 24], entry[23:6] = iteration count, entry[5:0] = jump amount.
- decode  in  1  decode request.
- addr  in  LOG_LOOP_CNT  loop name / table index (instruction bits [4:6]).
- independent  in  1  instruction bit [2], the independent-iterations flag.
- new_loop  in  1  instruction bit [3]; 1 = start-loop, 0 = end-loop.
- out_valid  out  1  decoded fields valid.
- is_new_loop  out  1  registered new_loop.
- is_independent  out  1  registered independent, gated by new_loop.
- iteration_count  out  ITER_W  entry iteration count.
- jump_amount  out  JUMP_W  entry jump amount.
- name  out  LOG_LOOP_CNT  registered addr.
- err  out  1  descriptor error (only with LOOP_MUX_ZERO_CHECK_EN).

## Operation
- Table: LOOP_CNT registers of ENTRY_W bits. On load, all entries are written from `in` in one cycle. With load low, the table holds its contents.
- Decode, on a cycle with decode high:
  - is_new_loop = new_loop.
  - is_independent = independent & new_loop, so it is always 0 for end-loop.
  - name = addr.
  - iteration_count = table[addr][23:6].
  - jump_amount = table[addr][5:0].
  - out_valid = 1.
- With decode low: out_valid = 0 and the data outputs hold their last values.
- All fields are passed through unmodified; no arithmetic.
- Load and decode in the same cycle: the decode reads the pre-load table contents. The new contents are visible from the next cycle.
- No internal state machine beyond the table and the output registers.

## Timing
- Reset (async assert, sync-to-clk deassert is the caller's concern): table = 0, out_valid = 0, is_new_loop = 0, is_independent = 0, iteration_count = 0, jump_amount = 0, name = 0, err = 0.
- Decode latency: 1 cycle. A request at edge N produces outputs valid after edge N.
- Load latency: 1 cycle. The table updates at the load edge.
- Back-to-back decodes are accepted every cycle, giving throughput of 1 per cycle.
- Reset asserted mid-operation clears the table immediately. A decode in flight is dropped (out_valid = 0).

## Configuration
- LOOP_MUX_ZERO_CHECK_EN defined:
  - err is registered alongside the outputs.
  - err = 1 for one cycle when a decode with new_loop = 1 selects an entry whose iteration_count == 0 or jump_amount == 0.
  - err = 0 otherwise.
- LOOP_MUX_ZERO_CHECK_EN undefined: err is tied to 0 and no check logic is built. All other behaviour is identical.

## Test plan
- Reset then decode: reset_n low, release, decode addr=5 -> out_valid=1, iteration_count=0, jump_amount=0, name=5.
- Load and decode:
  - Stimulus: load with entry3 = {18'd100, 6'd4}, then decode addr=3, new_loop=1, independent=1.
  - Required next cycle: iteration_count=100, jump_amount=4, is_new_loop=1, is_independent=1, name=3.
- End-loop gating: decode addr=3, new_loop=0, independent=1 -> is_new_loop=0, is_independent=0, iteration_count=100.
- Load/decode collision:
  - Stimulus: entry0 = {18'd7, 6'd2}. In the same cycle, load entry0 = {18'd9, 6'd1} and decode addr=0.
  - Required: that decode returns 7/2; a following decode returns 9/1.
- All 8 entries: load distinct values {i+1, i+1} for i = 0..7, decode addr 0..7 back-to-back -> each output matches one cycle later, out_valid continuously 1.
- LOOP_MUX_ZERO_CHECK_EN:
  - Stimulus: entry2 = {18'd0, 6'd3}, decode addr=2, new_loop=1.
  - Required: err=1 for one cycle. The same decode with new_loop=0 gives err=0.
